// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry circular buffer of {instruction, PC+4}
// pairs between fetch and decode, with flush and a NOP bubble when empty.
// Optional flush counter enabled by defining IFQ_FLUSH_CNT_EN.
module if_id_queue #(
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       PC_W   = 32,
  parameter int unsigned       DEPTH  = 4,
  parameter logic [DATA_W-1:0] NOP    = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_instr,
  input  logic [PC_W-1:0]              in_pcplus4,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_instr,
  output logic [PC_W-1:0]              out_pcplus4,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef IFQ_FLUSH_CNT_EN
  ,
  output logic [15:0]                  flush_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem    [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push, pop;

  // Handshake decode; flush suppresses both sides.
  always_comb begin
    in_ready  = (count_q != CntW'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
  end

  // Head presentation, masked to a bubble when empty.
  always_comb begin
    out_instr   = NOP;
    out_pcplus4 = '0;
    if (out_valid) begin
      out_instr   = instr_mem[rd_ptr_q];
      out_pcplus4 = pc_mem[rd_ptr_q];
    end
  end

  assign count = count_q;

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= in_instr;
      pc_mem[wr_ptr_q]    <= in_pcplus4;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

`ifdef IFQ_FLUSH_CNT_EN
  logic [15:0] flush_cnt_q;

  // Counts only flushes that actually discarded entries; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q <= '0;
    end else if (flush && (count_q != '0) && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=4): reset, fill/stall, full refusal,
// streaming push+pop, flush, held flush and asynchronous reset.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pcplus4;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pcplus4;
  logic        flush;
  logic [2:0]  count;
`ifdef IFQ_FLUSH_CNT_EN
  logic [15:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  if_id_queue #(
    .DATA_W (32),
    .PC_W   (32),
    .DEPTH  (4),
    .NOP    (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pcplus4  (in_pcplus4),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pcplus4 (out_pcplus4),
    .flush       (flush),
    .count       (count)
`ifdef IFQ_FLUSH_CNT_EN
    ,
    .flush_cnt   (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    in_instr   = 32'h20080005;
    in_pcplus4 = 32'h4;
    out_ready  = 1'b0;
    flush      = 1'b0;

    // Reset held with in_valid asserted
    repeat (3) cyc();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pcplus4, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef IFQ_FLUSH_CNT_EN
    check("rst_flush_cnt", flush_cnt, 0);
`endif

    // First push after release appears next cycle
    rst_n = 1'b1;
    cyc();
    check("first_valid", out_valid, 1);
    check("first_instr", out_instr, 32'h20080005);
    check("first_pc", out_pcplus4, 32'h4);
    check("first_count", count, 1);

    // Fill to DEPTH with decode stalled
    for (int i = 1; i <= 3; i++) begin
      in_instr   = 32'h100 + i;
      in_pcplus4 = 32'h1000 + 4 * i;
      cyc();
      check("stall_head", out_instr, 32'h20080005);
    end
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);

    // 5th offer is refused
    in_instr = 32'hDEADBEEF;
    cyc();
    check("refuse_count", count, 4);
    check("refuse_head", out_instr, 32'h20080005);

    // Full with pop: push still refused, no pass-through
    out_ready = 1'b1;
    cyc();
    check("fullpop_count", count, 3);
    check("fullpop_head", out_instr, 32'h101);
    check("fullpop_pc", out_pcplus4, 32'h1004);

    // Drain in order
    in_valid = 1'b0;
    cyc();
    check("drain_head2", out_instr, 32'h102);
    cyc();
    check("drain_head3", out_instr, 32'h103);
    check("drain_pc3", out_pcplus4, 32'h100C);
    cyc();
    check("drain_empty_valid", out_valid, 0);
    check("drain_empty_instr", out_instr, 32'h0);
    check("drain_empty_pc", out_pcplus4, 0);
    check("drain_empty_count", count, 0);

    // Build up two entries, then stream push+pop
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_instr   = 32'h200 + i;
      in_pcplus4 = 32'h2000 + 4 * i;
      cyc();
    end
    check("stream_pre_count", count, 2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_instr   = 32'h202 + k;
      in_pcplus4 = 32'h2008 + 4 * k;
      cyc();
      check("stream_count", count, 2);
      check("stream_head", out_instr, 32'h201 + k);
      check("stream_pc", out_pcplus4, 32'h2004 + 4 * k);
    end

    // Third entry then flush with in_valid and out_ready both high
    out_ready  = 1'b0;
    in_instr   = 32'h300;
    in_pcplus4 = 32'h3000;
    cyc();
    check("preflush_count", count, 3);
    flush      = 1'b1;
    out_ready  = 1'b1;
    in_instr   = 32'h400;
    in_pcplus4 = 32'h4000;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    check("flush_instr", out_instr, 32'h0);
    check("flush_pc", out_pcplus4, 0);
    check("flush_in_ready", in_ready, 1);
`ifdef IFQ_FLUSH_CNT_EN
    check("flush_cnt_1", flush_cnt, 1);
`endif

    // Held flush while empty: nothing accepted, counter unchanged
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h4FF;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("hold_count", count, 0);
      check("hold_in_ready", in_ready, 1);
    end
`ifdef IFQ_FLUSH_CNT_EN
    check("flush_cnt_hold", flush_cnt, 1);
`endif

    // Push right after flush is accepted normally
    flush      = 1'b0;
    out_ready  = 1'b0;
    in_instr   = 32'h500;
    in_pcplus4 = 32'h504;
    cyc();
    check("postflush_count", count, 1);
    check("postflush_instr", out_instr, 32'h500);
    check("postflush_pc", out_pcplus4, 32'h504);
    in_instr   = 32'h501;
    in_pcplus4 = 32'h508;
    cyc();
    in_valid = 1'b0;
    check("prereset_count", count, 2);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_count", count, 0);
    check("async_instr", out_instr, 32'h0);
    check("async_pc", out_pcplus4, 0);
    check("async_in_ready", in_ready, 1);
`ifdef IFQ_FLUSH_CNT_EN
    check("async_flush_cnt", flush_cnt, 0);
`endif
    rst_n = 1'b1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
